// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the next-PC unit operands, and runs the
// imem req/ready and decode valid/ack handshakes with redirect squashing.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ack,
    input  logic        redir_valid,
    input  logic [1:0]  redir_op,
    input  logic [31:0] redir_pc,
    input  logic [25:0] redir_imm,
    input  logic [31:0] redir_rd1,
    output logic [31:0] npc_pc,
    output logic [1:0]  npc_op,
    output logic [25:0] npc_imm,
    output logic [31:0] npc_rd1,
    input  logic [31:0] npc_in,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      state, state_nxt;
    logic        discard;
    logic [31:0] tgt_buf;
    logic [31:0] tgt;

    // Word-aligned result of the next-PC unit; every PC load goes through this.
    assign tgt = npc_in & ~32'h3;

    always_comb begin
        npc_pc  = pc;
        npc_op  = 2'd0;
        npc_imm = '0;
        npc_rd1 = '0;
        if (redir_valid) begin
            npc_pc  = redir_pc;
            npc_op  = redir_op;
            npc_imm = redir_imm;
            npc_rd1 = redir_rd1;
        end
    end

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!stall) state_nxt = REQ;
            REQ: begin
                if (imem_ready) begin
                    if (discard || redir_valid) state_nxt = stall ? IDLE : REQ;
                    else                        state_nxt = HOLD;
                end
            end
            HOLD: if (redir_valid || inst_ack) state_nxt = stall ? IDLE : REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc         <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            discard    <= 1'b0;
            tgt_buf    <= '0;
        end else begin
            case (state)
                IDLE: if (redir_valid) pc <= tgt;
                REQ: begin
                    if (!imem_ready) begin
                        // Keep the address stable; park the target until memory completes.
                        if (redir_valid) begin
                            tgt_buf <= tgt;
                            discard <= 1'b1;
                        end
                    end else if (discard || redir_valid) begin
                        discard <= 1'b0;
                        pc      <= redir_valid ? tgt : tgt_buf;
                    end else begin
                        inst       <= imem_rdata;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redir_valid || inst_ack) begin
                        inst_valid <= 1'b0;
                        pc         <= tgt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a behavioural next-PC unit.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ack;
    logic        redir_valid;
    logic [1:0]  redir_op;
    logic [31:0] redir_pc;
    logic [25:0] redir_imm;
    logic [31:0] redir_rd1;
    logic [31:0] npc_pc;
    logic [1:0]  npc_op;
    logic [25:0] npc_imm;
    logic [31:0] npc_rd1;
    logic [31:0] npc_in;
    logic [31:0] pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rstn(rstn), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ack(inst_ack),
        .redir_valid(redir_valid), .redir_op(redir_op), .redir_pc(redir_pc),
        .redir_imm(redir_imm), .redir_rd1(redir_rd1),
        .npc_pc(npc_pc), .npc_op(npc_op), .npc_imm(npc_imm), .npc_rd1(npc_rd1),
        .npc_in(npc_in), .pc(pc)
    );

    // Next-PC unit model: PLUS4, BRANCH (16-bit word offset), JUMP (26-bit index), REG.
    always_comb begin
        logic [31:0] p4;
        p4 = npc_pc + 32'd4;
        case (npc_op)
            2'd0:    npc_in = p4;
            2'd1:    npc_in = p4 + {{14{npc_imm[15]}}, npc_imm[15:0], 2'b00};
            2'd2:    npc_in = {p4[31:28], npc_imm, 2'b00};
            default: npc_in = npc_rd1;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic clear_inputs();
        stall = 0; imem_ready = 0; imem_rdata = 0; inst_ack = 0;
        redir_valid = 0; redir_op = 0; redir_pc = 0; redir_imm = 0; redir_rd1 = 0;
    endtask

    // Reset, release, and advance one cycle so the DUT sits in REQ at RESET_PC.
    task automatic do_reset();
        clear_inputs();
        rstn = 0;
        step();
        rstn = 1;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn = 0;
        step();
        chk("reset imem_req", {31'b0, imem_req}, 32'd0);
        chk("reset pc", pc, 32'h3000);
        chk("reset inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("reset inst", inst, 32'd0);
        chk("reset inst_pc", inst_pc, 32'd0);
        chk("reset npc_pc", npc_pc, 32'h3000);
        rstn = 1;
        step();
        chk("first req", {31'b0, imem_req}, 32'd1);
        chk("first addr", imem_addr, 32'h3000);
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'h3000 + 32'(4 * i);
            chk("seq req", {31'b0, imem_req}, 32'd1);
            chk("seq addr", imem_addr, a);
            chk("seq npc_op", {30'b0, npc_op}, 32'd0);
            imem_ready = 1; imem_rdata = 32'hA5A5_0000 + 32'(i);
            step();
            imem_ready = 0; inst_ack = 1;
            chk("seq valid", {31'b0, inst_valid}, 32'd1);
            chk("seq inst", inst, 32'hA5A5_0000 + 32'(i));
            chk("seq inst_pc", inst_pc, a);
            chk("seq hold req", {31'b0, imem_req}, 32'd0);
            step();
            inst_ack = 0;
            chk("seq valid drop", {31'b0, inst_valid}, 32'd0);
        end
    endtask

    task automatic test_hold();
        do_reset();
        imem_ready = 1; imem_rdata = 32'h2408_0001;
        step();
        imem_ready = 0; imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold inst", inst, 32'h2408_0001);
            chk("hold valid", {31'b0, inst_valid}, 32'd1);
            chk("hold req", {31'b0, imem_req}, 32'd0);
        end
        inst_ack = 1; stall = 1;
        step();
        inst_ack = 0;
        chk("stalled after ack req", {31'b0, imem_req}, 32'd0);
        chk("stalled pc", pc, 32'h3004);
        step();
        chk("stalled idle req", {31'b0, imem_req}, 32'd0);
        stall = 0;
        step();
        chk("hold next req", {31'b0, imem_req}, 32'd1);
        chk("hold next addr", imem_addr, 32'h3004);
    endtask

    task automatic test_redirect_pending();
        do_reset();
        step();
        redir_valid = 1; redir_op = 2; redir_pc = 32'h3000; redir_imm = 26'h100;
        #1;
        chk("npc_op mux", {30'b0, npc_op}, 32'd2);
        chk("npc_imm mux", {6'b0, npc_imm}, 32'h100);
        step();
        redir_valid = 0; redir_op = 0; redir_imm = 0;
        chk("pending addr stable", imem_addr, 32'h3000);
        chk("pending req", {31'b0, imem_req}, 32'd1);
        step();
        chk("pending addr stable2", imem_addr, 32'h3000);
        imem_ready = 1; imem_rdata = 32'h0000_0100;
        step();
        imem_ready = 0;
        chk("dropped valid", {31'b0, inst_valid}, 32'd0);
        chk("dropped inst", inst, 32'd0);
        chk("redirected addr", imem_addr, 32'h0000_0400);
        chk("redirected req", {31'b0, imem_req}, 32'd1);
    endtask

    task automatic test_double_redirect();
        do_reset();
        redir_valid = 1; redir_op = 2; redir_pc = 32'h3000; redir_imm = 26'h140;
        step();
        redir_imm = 26'h180;
        step();
        redir_valid = 0;
        imem_ready = 1; imem_rdata = 32'h1111_1111;
        step();
        chk("double valid", {31'b0, inst_valid}, 32'd0);
        chk("double addr", imem_addr, 32'h0000_0600);
        imem_rdata = 32'h2222_2222;
        step();
        imem_ready = 0;
        chk("double fetch valid", {31'b0, inst_valid}, 32'd1);
        chk("double fetch inst_pc", inst_pc, 32'h0000_0600);
        chk("double fetch inst", inst, 32'h2222_2222);
        // Redirect coincident with completion beats the buffered target.
        do_reset();
        redir_valid = 1; redir_op = 2; redir_imm = 26'h140;
        step();
        redir_imm = 26'h1C0; imem_ready = 1;
        step();
        redir_valid = 0; imem_ready = 0;
        chk("late redir valid", {31'b0, inst_valid}, 32'd0);
        chk("late redir addr", imem_addr, 32'h0000_0700);
    endtask

    task automatic test_hold_redirect();
        do_reset();
        imem_ready = 1; imem_rdata = 32'h0000_0011;
        step();
        imem_ready = 0;
        redir_valid = 1; redir_op = 3; redir_pc = 32'h3000; redir_rd1 = 32'h0000_3042; inst_ack = 1;
        #1;
        chk("npc_rd1 mux", npc_rd1, 32'h0000_3042);
        step();
        redir_valid = 0; inst_ack = 0;
        chk("hold redir valid", {31'b0, inst_valid}, 32'd0);
        chk("hold redir addr", imem_addr, 32'h0000_3040);
        chk("hold redir req", {31'b0, imem_req}, 32'd1);
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        imem_ready = 1;
        step();
        imem_ready = 0; inst_ack = 1;
        step();
        inst_ack = 0;
        chk("pre-reset addr", imem_addr, 32'h3004);
        stall = 1;
        rstn = 0;
        #1;
        chk("async req drop", {31'b0, imem_req}, 32'd0);
        chk("async pc", pc, 32'h3000);
        step();
        rstn = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall idle req", {31'b0, imem_req}, 32'd0);
        end
        redir_valid = 1; redir_op = 2; redir_pc = 32'h3000; redir_imm = 26'h200;
        step();
        redir_valid = 0;
        chk("idle redir pc", pc, 32'h0000_0800);
        chk("idle redir req", {31'b0, imem_req}, 32'd0);
        stall = 0;
        step();
        chk("unstall req", {31'b0, imem_req}, 32'd1);
        chk("unstall addr", imem_addr, 32'h0000_0800);
    endtask

    initial begin
        clear_inputs();
        rstn = 0;
        test_reset();
        test_sequential();
        test_hold();
        test_redirect_pending();
        test_double_redirect();
        test_hold_redirect();
        test_reset_mid_req();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Fetch sequencer that owns the architectural PC register and drives the combinational next-PC unit: it selects the next-PC operation, operands and base PC each cycle. It runs a req/ready handshake to instruction memory and a valid/ack handshake to decode. Redirects (branch/jump/jr) from execute take priority over sequential advance. Sits between instruction memory, the next-PC unit and decode in the CPU datapath.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
stall  in  1  suppress issue of new fetch requests
imem_req  out  1  fetch request; held until imem_ready
imem_addr  out  32  fetch address (= pc), stable while imem_req=1
imem_ready  in  1  memory completes request this cycle
imem_rdata  in  32  instruction word, valid when imem_ready=1
inst_valid  out  1  instruction held for decode
inst  out  32  instruction word
inst_pc  out  32  address of inst
inst_ack  in  1  decode consumes inst this cycle
redir_valid  in  1  single-cycle redirect pulse from execute
redir_op  in  2  next-PC op: 0 PLUS4, 1 BRANCH, 2 JUMP, 3 REG
redir_pc  in  32  PC of redirecting instruction
redir_imm  in  26  immediate / jump index
redir_rd1  in  32  register target for REG
npc_pc  out  32  to next-PC unit: base PC
npc_op  out  2  to next-PC unit: operation
npc_imm  out  26  to next-PC unit: immediate
npc_rd1  out  32  to next-PC unit: register operand
npc_in  in  32  next-PC unit result
pc  out  32  current PC register

Behaviour:
- Reset (async, rstn=0): pc=RESET_PC, state=IDLE, inst_valid=0, inst=0, inst_pc=0, discard=0, tgt_buf=0; imem_req=0 immediately. An outstanding memory transaction is abandoned.
- Next-PC operand mux (combinational): redir_valid=1 -> npc_pc=redir_pc, npc_op=redir_op, npc_imm=redir_imm, npc_rd1=redir_rd1. Otherwise npc_pc=pc, npc_op=0 (PLUS4), npc_imm=0, npc_rd1=0.
- Every PC load uses {npc_in[31:2],2'b00}; low bits are forced to zero.
- imem_req=1 only in REQ; imem_addr=pc always.
- FSM states: IDLE, REQ, HOLD.
- IDLE: if redir_valid, load pc. Go to REQ when stall=0, else stay.
- REQ, imem_ready=0:
  - redir_valid -> tgt_buf<=npc_in, discard<=1; pc unchanged so the address stays stable.
  - A second redirect overwrites tgt_buf (latest wins).
- REQ, imem_ready=1:
  - If discard=1 or redir_valid=1: data dropped, discard<=0; pc <= redirect target (current redir_valid wins over tgt_buf). Next state REQ if stall=0, else IDLE.
  - Otherwise: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, go to HOLD.
- HOLD: inst/inst_pc/inst_valid are held stable until ack or redirect.
  - redir_valid (priority over inst_ack): inst_valid<=0, pc<=target.
  - inst_ack without redirect: inst_valid<=0, pc<=npc_in (pc+4).
  - Either way, next state REQ if stall=0, else IDLE.
- stall never aborts an active REQ; it only blocks entry into REQ.
- Latency: fetch issue the cycle after entering REQ. Best-case throughput is one instruction per 2 cycles (REQ -> HOLD -> REQ). PC wraps modulo 2^32 with no error.
- A redirect never causes a stale instruction to reach decode: inst_valid is never asserted for data fetched before a redirect.

Test Plan:
- Reset release, imem_ready=1 every REQ, inst_ack=1 in HOLD -> imem_addr 0x3000, 0x3004, 0x3008; inst_pc matches; inst_valid alternates 1/0.
- Hold inst_ack=0 for 5 cycles in HOLD with inst=0x2408_0001 -> inst and inst_valid stable, imem_req=0; ack -> next imem_addr 0x3004.
- In REQ with ready delayed 3 cycles, pulse redir_valid, op=JUMP, imem_rdata=0x0000_0100 (next-PC unit returns 0x0000_0400) -> addr stays 0x3000 until ready; data dropped, inst_valid stays 0; next imem_addr 0x0000_0400.
- Two redirects in one pending REQ (targets 0x500 then 0x600) -> next fetch at 0x600 only.
- In HOLD, redir_valid and inst_ack together with op=REG, rd1=0x0000_3042 -> inst_valid drops, next imem_addr 0x0000_3040.
- Drop rstn mid-REQ, stall=1 at release -> imem_req=0 immediately, pc=0x3000; stays IDLE until stall=0.
